// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: branch resolution, single-port data memory with a
// two-edge load path that stalls upstream for one cycle, and the MEM/WB register.
module mem_stage_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Branch,
  input  logic [31:0] MEM_BranchAddr,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ReadData2,
  input  logic        MEM_Zero,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        Stall,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [4:0]  WB_WriteReg,
  output logic        MisalignErr
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             misalign;
  logic             load_go;
  logic             mem_we;
  logic             bubble;
  logic [31:0]      rd_data_p0;

  // Address bits above the memory span are intentionally dropped (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^MEM_ALUResult[31:IDX_W+2];

  assign PCSrc        = MEM_Branch & MEM_Zero;
  assign BranchTarget = MEM_BranchAddr;

  always_comb begin
    idx       = MEM_ALUResult[IDX_W+1:2];
    misalign  = (MEM_MemRead | MEM_MemWrite) && (MEM_ALUResult[1:0] != 2'b00);
    mem_we    = MEM_MemWrite & ~misalign;
    load_go   = 1'b0;
    Stall     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MEM_MemRead && !misalign) begin
          load_go   = 1'b1;
          Stall     = ~reset;
          state_nxt = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bubble = (state == IDLE) && (load_go || misalign);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: memory array write and registered read (no reset on storage)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= MEM_ReadData2;
    end
    if (load_go) begin
      rd_data_p0 <= mem[idx];
    end
  end

  // Stage p1: MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_RegWrite  <= 1'b0;
      WB_MemtoReg  <= 1'b0;
      WB_ReadData  <= 32'd0;
      WB_ALUResult <= 32'd0;
      WB_WriteReg  <= 5'd0;
      MisalignErr  <= 1'b0;
    end else begin
      if (misalign) begin
        MisalignErr <= 1'b1;
      end
      WB_ALUResult <= MEM_ALUResult;
      WB_WriteReg  <= MEM_WriteReg;
      if (bubble) begin
        WB_RegWrite <= 1'b0;
        WB_MemtoReg <= 1'b0;
      end else begin
        WB_RegWrite <= MEM_RegWrite;
        WB_MemtoReg <= MEM_MemtoReg;
      end
      if (state == LOAD_WAIT) begin
        WB_ReadData <= rd_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Randomized scoreboard bench for mem_stage_unit with a word-addressed
// reference memory and directed scenarios for loads, wrap, misalignment and reset.
module tb_mem_stage_unit;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite, MEM_Branch;
  logic [31:0] MEM_BranchAddr, MEM_ALUResult, MEM_ReadData2;
  logic        MEM_Zero;
  logic [4:0]  MEM_WriteReg;
  logic        PCSrc, Stall, WB_RegWrite, WB_MemtoReg, MisalignErr;
  logic [31:0] BranchTarget, WB_ReadData, WB_ALUResult;
  logic [4:0]  WB_WriteReg;

  mem_stage_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Branch(MEM_Branch), .MEM_BranchAddr(MEM_BranchAddr),
    .MEM_ALUResult(MEM_ALUResult), .MEM_ReadData2(MEM_ReadData2),
    .MEM_Zero(MEM_Zero), .MEM_WriteReg(MEM_WriteReg),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
    .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
    .WB_WriteReg(WB_WriteReg), .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bubble;
    bit          rw;
    bit          m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state: word memory, pending-load flag, last loaded value, sticky error.
  logic [31:0] mmem [int];
  bit          m_wait = 0;
  logic [31:0] m_load = 0;
  logic [31:0] m_rdata = 0;
  bit          m_err = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rw, input bit m2r, input bit rd, input bit wr,
                       input bit br, input bit z, input logic [31:0] ba,
                       input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] wrg);
    exp_t e;
    bit   mis;
    bit   exp_stall;
    @(negedge clk);
    MEM_RegWrite = rw; MEM_MemtoReg = m2r; MEM_MemRead = rd; MEM_MemWrite = wr;
    MEM_Branch = br; MEM_Zero = z; MEM_BranchAddr = ba; MEM_ALUResult = alu;
    MEM_ReadData2 = d2; MEM_WriteReg = wrg;
    #1;
    mis = (rd || wr) && (alu[1:0] != 2'b00);
    exp_stall = !m_wait && rd && !mis;
    check("pcsrc", PCSrc, br & z);
    check("branch_target", BranchTarget, ba);
    check("stall", Stall, exp_stall);
    e.rw = rw; e.m2r = m2r; e.alu = alu; e.wr = wrg; e.bubble = 0;
    if (m_wait) begin
      m_rdata = m_load;
      m_wait  = 0;
    end else if (exp_stall) begin
      e.bubble = 1;
      m_load   = mmem.exists(widx(alu)) ? mmem[widx(alu)] : 32'd0;
      m_wait   = 1;
    end else if (mis) begin
      e.bubble = 1;
    end
    if (mis) m_err = 1;
    if (wr && !mis) mmem[widx(alu)] = d2;
    e.rdata = m_rdata;
    e.err   = m_err;
    q.push_back(e);
  endtask

  // A load that stalls is re-presented unchanged in the following cycle.
  task automatic issue(input bit rw, input bit m2r, input bit rd, input bit wr,
                       input bit br, input bit z, input logic [31:0] ba,
                       input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] wrg);
    cycle(rw, m2r, rd, wr, br, z, ba, alu, d2, wrg);
    if (m_wait) cycle(rw, m2r, rd, wr, br, z, ba, alu, d2, wrg);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    issue(0, 0, 0, 1, 0, 0, 32'd0, a, d, 5'd0);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] rdst);
    issue(1, 1, 1, 0, 0, 0, 32'd0, a, 32'd0, rdst);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("wb_regwrite", WB_RegWrite, e.bubble ? 1'b0 : e.rw);
      check("wb_memtoreg", WB_MemtoReg, e.bubble ? 1'b0 : e.m2r);
      if (!e.bubble) begin
        check("wb_readdata", WB_ReadData, e.rdata);
        check("wb_aluresult", WB_ALUResult, e.alu);
        check("wb_writereg", WB_WriteReg, e.wr);
      end
      check("misalign_err", MisalignErr, e.err);
    end
  end

  initial begin
    reset = 1'b1;
    MEM_RegWrite = 0; MEM_MemtoReg = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
    MEM_Branch = 0; MEM_Zero = 0; MEM_BranchAddr = 0; MEM_ALUResult = 0;
    MEM_ReadData2 = 0; MEM_WriteReg = 0;
    #1;
    check("reset_stall", Stall, 0);
    check("reset_regwrite", WB_RegWrite, 0);
    check("reset_readdata", WB_ReadData, 0);
    check("reset_misalign", MisalignErr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Branch resolution
    issue(0, 0, 0, 0, 1, 1, 32'h40, 32'h0, 32'h0, 5'd0);
    issue(0, 0, 0, 0, 1, 0, 32'h40, 32'h0, 32'h0, 5'd0);
    issue(0, 0, 0, 0, 0, 1, 32'h80, 32'h0, 32'h0, 5'd0);

    // Define every word, using random upper address bits to exercise wrap
    for (int i = 0; i < MEM_WORDS; i++)
      store(($urandom() & ~32'h3FF) | (i << 2), $urandom());

    // Store then immediately load
    store(32'h10, 32'hDEADBEEF);
    load(32'h10, 5'd9);
    nop();
    check("st_ld_data", WB_ReadData, 32'hDEADBEEF);
    check("st_ld_writereg", WB_WriteReg, 9);
    check("st_ld_regwrite", WB_RegWrite, 1);
    check("st_ld_memtoreg", WB_MemtoReg, 1);

    // Wrap-around at MEM_WORDS*4
    store(32'h400, 32'h1234);
    load(32'h000, 5'd4);
    nop();
    check("wrap_data", WB_ReadData, 32'h1234);

    // Back-to-back loads
    load(32'h0, 5'd5);
    load(32'h4, 5'd6);
    nop();

    // Misaligned load, then error stays sticky through valid accesses
    issue(1, 1, 1, 0, 0, 0, 32'h0, 32'h13, 32'h0, 5'd7);
    nop();
    check("misalign_flag", MisalignErr, 1);
    load(32'h8, 5'd8);
    store(32'hC, 32'h55);
    nop();
    check("misalign_sticky", MisalignErr, 1);

    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = $urandom() & ~32'h3;
      case (op)
        0, 1, 2: load(a, 5'($urandom_range(1, 31)));
        3, 4:    store(a, $urandom());
        5:       issue(1'($urandom()), 0, 1'($urandom()), 0, 0, 0, 32'd0,
                       a | 32'($urandom_range(1, 3)), $urandom(), 5'($urandom()));
        default: issue(1'($urandom()), 0, 0, 0, 1'($urandom()), 1'($urandom()),
                       $urandom(), $urandom(), $urandom(), 5'($urandom()));
      endcase
    end

    // Reset while the load is in LOAD_WAIT abandons it
    cycle(1, 1, 1, 0, 0, 0, 32'd0, 32'h20, 32'd0, 5'd10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_stall", Stall, 0);
    check("rst_mid_regwrite", WB_RegWrite, 0);
    check("rst_mid_memtoreg", WB_MemtoReg, 0);
    check("rst_mid_readdata", WB_ReadData, 0);
    check("rst_mid_aluresult", WB_ALUResult, 0);
    check("rst_mid_writereg", WB_WriteReg, 0);
    check("rst_mid_misalign", MisalignErr, 0);
    MEM_MemRead = 0; MEM_RegWrite = 0; MEM_MemtoReg = 0;
    q.delete();
    m_wait = 0; m_rdata = 0; m_err = 0;
    @(negedge clk);
    reset = 1'b0;
    issue(1, 0, 0, 0, 0, 0, 32'd0, 32'd7, 32'd0, 5'd3);
    nop();
    check("post_rst_alu", WB_ALUResult, 7);
    check("post_rst_writereg", WB_WriteReg, 3);
    check("post_rst_regwrite", WB_RegWrite, 1);
    check("post_rst_readdata", WB_ReadData, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
